// File: rtl/ascon_perm_stream.sv
// Serial-in/serial-out Ascon permutation engine: loads a 320-bit state in BW-bit slices,
// applies p^nr one round per clock, then streams the result out with ready/valid on both sides.
module ascon_perm_stream #(
  parameter int BW    = 64,
  parameter int RND_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BW-1:0]    in_data,
  input  logic [RND_W-1:0] rounds_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BW-1:0]    out_data,
  output logic             out_last,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int NB = 320 / BW;

  if (BW != 32 && BW != 64) begin : g_bad_bw
    $error("ascon_perm_stream: BW must be 32 or 64");
  end

  // Handshake rule on both sides: a beat transfers on a rising edge where valid and ready are
  // both high; valid never depends on ready, and data is held stable while valid & !ready.
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PERM = 2'd2, UNLOAD = 2'd3} fsm_t;

  fsm_t         fsm;
  logic [319:0] s;
  logic [3:0]   beat_cnt;
  logic [3:0]   rnd_cnt;
  logic [3:0]   nr;
  logic [3:0]   nr_clamped;
  logic [7:0]   rc;

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] c0, c1, c2, c3, c4;
  logic [319:0] round_s;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  assign nr_clamped = (int'(rounds_i) > 12) ? 4'd12 : 4'(rounds_i);
  assign rc         = {4'hF - rnd_cnt, rnd_cnt};

  // One Ascon round on the whole state: constant, bit-sliced S-box, linear diffusion.
  always_comb begin
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128] ^ {56'b0, rc};
    x3 = s[127:64];
    x4 = s[63:0];
    a0 = x0 ^ x4;
    a1 = x1;
    a2 = x2 ^ x1;
    a3 = x3;
    a4 = x4 ^ x3;
    b0 = a0 ^ (~a1 & a2);
    b1 = a1 ^ (~a2 & a3);
    b2 = a2 ^ (~a3 & a4);
    b3 = a3 ^ (~a4 & a0);
    b4 = a4 ^ (~a0 & a1);
    c0 = b0 ^ b4;
    c1 = b1 ^ b0;
    c2 = ~b2;
    c3 = b3 ^ b2;
    c4 = b4;
    round_s = {c0 ^ rotr(c0, 19) ^ rotr(c0, 28),
               c1 ^ rotr(c1, 61) ^ rotr(c1, 39),
               c2 ^ rotr(c2, 1)  ^ rotr(c2, 6),
               c3 ^ rotr(c3, 10) ^ rotr(c3, 17),
               c4 ^ rotr(c4, 7)  ^ rotr(c4, 41)};
  end

  // Slices arrive and leave MSB-first, so the state register works as a shift register:
  // after NB shifts in, slice 0 sits at the top; unloading shifts it back out from the top.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm       <= IDLE;
      s         <= '0;
      beat_cnt  <= '0;
      rnd_cnt   <= '0;
      nr        <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          if (in_valid && in_ready) begin
            s        <= {s[319-BW:0], in_data};
            nr       <= nr_clamped;
            beat_cnt <= 4'd1;
            busy     <= 1'b1;
            fsm      <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            s <= {s[319-BW:0], in_data};
            if (beat_cnt == 4'(NB - 1)) begin
              beat_cnt <= '0;
              in_ready <= 1'b0;
              if (nr == 4'd0) begin
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                fsm       <= UNLOAD;
              end else begin
                rnd_cnt <= 4'd12 - nr;
                fsm     <= PERM;
              end
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        PERM: begin
          s       <= round_s;
          rnd_cnt <= rnd_cnt + 4'd1;
          if (rnd_cnt == 4'd11) begin
            beat_cnt  <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            fsm       <= UNLOAD;
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            s <= s << BW;
            if (beat_cnt == 4'(NB - 1)) begin
              beat_cnt  <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              fsm       <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
              out_last <= (beat_cnt == 4'(NB - 2));
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign out_data  = (fsm == UNLOAD) ? s[319 -: BW] : '0;
  assign dbg_state = fsm;

endmodule

// File: tb/tb_ascon_perm_stream.sv
// Bench for ascon_perm_stream: one BW=64 and one BW=32 instance, directed transactions checked
// against an S-box-table reference model through an expected-slice queue.
module tb_ascon_perm_stream;

  logic clk;
  logic rstn;

  logic        sel32;
  logic        in_valid_d;
  logic        out_ready_d;
  logic [63:0] in_data_d;
  logic [3:0]  rounds_d;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [63:0] a_in_data, a_out_data;
  logic [1:0]  a_dbg;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_dbg;

  logic        in_ready_v, out_valid_v, out_last_v, busy_v;
  logic [63:0] out_data_v;

  int errors = 0;
  int checks = 0;
  int nb = 5;
  int bw = 64;
  logic [63:0] exp_q[$];

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  ascon_perm_stream #(.BW(64), .RND_W(4)) dut_a (
    .clk(clk), .rstn(rstn), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .rounds_i(rounds_d), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .busy(a_busy), .dbg_state(a_dbg));

  ascon_perm_stream #(.BW(32), .RND_W(4)) dut_b (
    .clk(clk), .rstn(rstn), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .rounds_i(rounds_d), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy), .dbg_state(b_dbg));

  assign a_in_valid  = in_valid_d & ~sel32;
  assign b_in_valid  = in_valid_d & sel32;
  assign a_in_data   = in_data_d;
  assign b_in_data   = in_data_d[31:0];
  assign a_out_ready = out_ready_d & ~sel32;
  assign b_out_ready = out_ready_d & sel32;
  assign in_ready_v  = sel32 ? b_in_ready : a_in_ready;
  assign out_valid_v = sel32 ? b_out_valid : a_out_valid;
  assign out_last_v  = sel32 ? b_out_last : a_out_last;
  assign busy_v      = sel32 ? b_busy : a_busy;
  assign out_data_v  = sel32 ? {32'b0, b_out_data} : a_out_data;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] model_round(input logic [319:0] s, input int r);
    logic [63:0] x[5];
    logic [63:0] y[5];
    logic [4:0]  v;
    for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
    x[2] = x[2] ^ {56'b0, 4'(15 - r), 4'(r)};
    for (int c = 0; c < 64; c++) begin
      v = {x[0][c], x[1][c], x[2][c], x[3][c], x[4][c]};
      v = SBOX[v];
      for (int i = 0; i < 5; i++) y[i][c] = v[4-i];
    end
    x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
    x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
    x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
    x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
    x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] p_model(input logic [319:0] s, input int nr);
    logic [319:0] t = s;
    for (int r = 12 - nr; r < 12; r++) t = model_round(t, r);
    return t;
  endfunction

  function automatic logic [63:0] slice(input logic [319:0] st, input int k);
    logic [319:0] t = st << (k * bw);
    return (bw == 64) ? t[319:256] : {32'b0, t[319:288]};
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] s = '0;
    for (int i = 0; i < 10; i++) s = {s[287:0], $urandom()};
    return s;
  endfunction

  task automatic select(input logic w32);
    sel32 = w32;
    bw    = w32 ? 32 : 64;
    nb    = w32 ? 10 : 5;
  endtask

  // Driver: returns half a cycle after the edge that accepts the last slice.
  task automatic load(input string tag, input logic [319:0] st, input int rnd_in, input bit gaps);
    int k = 0;
    int guard = 0;
    while (k < nb && guard < 400) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid_d = 1'b0;
      end else begin
        in_valid_d = 1'b1;
        in_data_d  = slice(st, k);
        rounds_d   = (k == 0) ? 4'(rnd_in) : 4'($urandom_range(0, 15));
        if (in_ready_v) k++;
      end
    end
    check({tag, " load beats"}, 64'(k), 64'(nb));
    @(negedge clk);
    in_valid_d = 1'b0;
  endtask

  task automatic push_expected(input logic [319:0] res);
    for (int k = 0; k < nb; k++) exp_q.push_back(slice(res, k));
  endtask

  task automatic unload(input string tag, input bit stalls, inout bit leak);
    int k = 0;
    int guard = 0;
    int hold = 0;
    logic [63:0] expv;
    while (k < nb && guard < 400) begin
      guard++;
      if (in_ready_v) leak = 1'b1;
      if (out_last_v) in_valid_d = 1'b0;
      if (stalls && k == 4 && hold < 3) begin
        out_ready_d = 1'b0;
        hold++;
      end else if (stalls && $urandom_range(0, 3) == 0) begin
        out_ready_d = 1'b0;
      end else begin
        out_ready_d = 1'b1;
      end
      expv = (exp_q.size() > 0) ? exp_q[0] : 64'hdead;
      check({tag, " out_valid"}, 64'(out_valid_v), 64'd1);
      check({tag, " out_data"}, out_data_v, expv);
      check({tag, " out_last"}, 64'(out_last_v), 64'(k == nb - 1));
      if (out_ready_d && out_valid_v) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        k++;
      end
      @(negedge clk);
    end
    out_ready_d = 1'b0;
    in_valid_d  = 1'b0;
    check({tag, " unload beats"}, 64'(k), 64'(nb));
  endtask

  // Full transaction with garbage input offered during PERM/UNLOAD (must be ignored).
  task automatic run_txn(input string tag, input logic [319:0] st, input int rnd_in,
                         input int exp_nr, input bit gaps, input bit stalls);
    int lat = 0;
    bit leak = 1'b0;
    load(tag, st, rnd_in, gaps);
    push_expected(p_model(st, exp_nr));
    in_valid_d = 1'b1;
    in_data_d  = {$urandom(), $urandom()};
    while (!out_valid_v && lat < 50) begin
      if (in_ready_v || !busy_v) leak = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_nr));
    unload(tag, stalls, leak);
    check({tag, " in_ready low in PERM/UNLOAD"}, 64'(leak), 64'd0);
    check({tag, " idle out_valid"}, 64'(out_valid_v), 64'd0);
    check({tag, " idle out_data"}, out_data_v, 64'd0);
    check({tag, " idle busy"}, 64'(busy_v), 64'd0);
    check({tag, " idle in_ready"}, 64'(in_ready_v), 64'd1);
    check({tag, " queue drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [319:0] st;
    rstn        = 1'b0;
    in_valid_d  = 1'b0;
    out_ready_d = 1'b0;
    in_data_d   = '0;
    rounds_d    = '0;
    select(1'b0);

    repeat (3) @(negedge clk);
    check("reset a in_ready", 64'(a_in_ready), 64'd0);
    check("reset a out_valid", 64'(a_out_valid), 64'd0);
    check("reset a out_last", 64'(a_out_last), 64'd0);
    check("reset a out_data", a_out_data, 64'd0);
    check("reset a busy", 64'(a_busy), 64'd0);
    check("reset a state", 64'(a_dbg), 64'd0);
    check("reset b in_ready", 64'(b_in_ready), 64'd0);
    check("reset b out_data", 64'(b_out_data), 64'd0);
    rstn = 1'b1;
    #1;
    check("in_ready before first edge", 64'(a_in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("in_ready after first edge", 64'(a_in_ready), 64'd1);
    check("b in_ready after first edge", 64'(b_in_ready), 64'd1);

    // T1: nr=0 passthrough
    st = {64'h0123456789abcdef, 64'h1111111111111111, 64'h2222222222222222,
          64'h3333333333333333, 64'h4444444444444444};
    run_txn("t1_nr0", st, 0, 0, 1'b0, 1'b0);

    // T2: nr=1 on a random state (round constant 0x4B)
    run_txn("t2_nr1", rand_state(), 1, 1, 1'b0, 1'b0);

    // T3: p12 of the all-zero state
    run_txn("t3_nr12_zero", '0, 12, 12, 1'b0, 1'b0);

    // T4: BW=32 with input gaps and output stalls
    select(1'b1);
    run_txn("t4_bw32_nr6", rand_state(), 6, 6, 1'b1, 1'b1);
    run_txn("t4_bw32_nr8", rand_state(), 8, 8, 1'b1, 1'b1);
    run_txn("t4_bw32_nr0", rand_state(), 0, 0, 1'b1, 1'b1);

    // T5: rounds_i above 12 clamps; later-beat rounds_i is random and must not matter
    select(1'b0);
    run_txn("t5_r15", rand_state(), 15, 12, 1'b1, 1'b1);
    run_txn("t5_r3", rand_state(), 3, 3, 1'b0, 1'b1);

    // T6: reset while permuting, then a fresh passthrough
    load("t6_abort", rand_state(), 12, 1'b0);
    repeat (5) @(negedge clk);
    check("t6 in PERM before reset", 64'(a_dbg), 64'd2);
    rstn = 1'b0;
    #1;
    check("t6 reset in_ready", 64'(a_in_ready), 64'd0);
    check("t6 reset out_valid", 64'(a_out_valid), 64'd0);
    check("t6 reset out_last", 64'(a_out_last), 64'd0);
    check("t6 reset out_data", a_out_data, 64'd0);
    check("t6 reset busy", 64'(a_busy), 64'd0);
    check("t6 reset state", 64'(a_dbg), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("t6 in_ready after release", 64'(a_in_ready), 64'd1);
    check("t6 no residual output", 64'(a_out_valid), 64'd0);
    run_txn("t6_fresh_nr0", rand_state(), 0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
